// File: rtl/sail_pkg.sv
// Constants shared across sail-core blocks.
package sail_pkg;

  localparam int unsigned XLEN = 32;

endpackage : sail_pkg

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead slice. Exposes group generate/propagate so that a
// second-level lookahead unit can compute each slice's carry-in.
module adder_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       g,
  output logic       p
);

  logic [3:0] bit_g;
  logic [3:0] bit_p;
  logic [3:0] carry;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  // Fully expanded lookahead terms; no bit-to-bit ripple inside the slice.
  assign carry[0] = cin;
  assign carry[1] = bit_g[0]
                  | (bit_p[0] & cin);
  assign carry[2] = bit_g[1]
                  | (bit_p[1] & bit_g[0])
                  | (bit_p[1] & bit_p[0] & cin);
  assign carry[3] = bit_g[2]
                  | (bit_p[2] & bit_g[1])
                  | (bit_p[2] & bit_p[1] & bit_g[0])
                  | (bit_p[2] & bit_p[1] & bit_p[0] & cin);

  assign sum = bit_p ^ carry;

  assign g = bit_g[3]
           | (bit_p[3] & bit_g[2])
           | (bit_p[3] & bit_p[2] & bit_g[1])
           | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
  assign p = &bit_p;

endmodule : adder_cla4

// File: rtl/adder32.sv
// Registered modulo-2^WIDTH adder for the PC+4 / branch-target paths.
// Two-level carry lookahead: 4-bit CLA slices plus a slice-carry unit.
module adder32
  import sail_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN  // must be a multiple of 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned NS = WIDTH / 4;

  logic [NS-1:0]    grp_g;
  logic [NS-1:0]    grp_p;
  logic [NS-1:0]    slice_cin;
  logic [WIDTH-1:0] sum_w;
  logic             term;

  genvar s;
  generate
    for (s = 0; s < NS; s++) begin : g_slice
      adder_cla4 u_cla4 (
        .a   (input1[4*s +: 4]),
        .b   (input2[4*s +: 4]),
        .cin (slice_cin[s]),
        .sum (sum_w[4*s +: 4]),
        .g   (grp_g[s]),
        .p   (grp_p[s])
      );
    end
  endgenerate

  // Each slice carry is a flat sum of products over lower-slice (G,P);
  // carry-in to slice 0 is 0 and the final carry-out is dropped.
  always_comb begin
    slice_cin = '0;
    term      = 1'b0;
    for (int unsigned i = 1; i < NS; i++) begin
      for (int unsigned j = 0; j < i; j++) begin
        term = grp_g[j];
        for (int unsigned k = j + 1; k < i; k++) begin
          term = term & grp_p[k];
        end
        slice_cin[i] = slice_cin[i] | term;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= sum_w;
    end
  end

endmodule : adder32

// File: tb/tb_adder32.sv
// Directed and random checks of the registered 32-bit adder.
module tb_adder32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [31:0] out;

  int unsigned errors = 0;
  int unsigned checks = 0;

  adder32 #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .input1 (input1),
    .input2 (input2),
    .out    (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply operands, wait for the next edge, sample 1 time unit after it.
  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    input1 = a;
    input2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb, rexp;

    rst    = 1'b1;
    input1 = 32'd1234;
    input2 = 32'd5678;
    @(posedge clk); #1;
    check("reset_cycle1", out, 32'd0);
    @(posedge clk); #1;
    check("reset_cycle2", out, 32'd0);

    rst = 1'b0;
    apply(32'd1234, 32'd5678);
    check("after_reset", out, 32'd6912);

    apply(32'd0, 32'd0);
    check("zero_zero", out, 32'd0);
    apply(32'd0, 32'd10);
    check("zero_ten", out, 32'd10);
    // Not yet updated mid-cycle: still holds previous sum.
    input1 = 32'd1000;
    input2 = 32'd10;
    #3;
    check("hold_between_edges", out, 32'd10);
    @(posedge clk); #1;
    check("k_plus_ten", out, 32'd1010);

    // Only the value present at the edge is sampled.
    input1 = 32'd5;
    input2 = 32'd5;
    #2;
    apply(32'd7, 32'd7);
    check("edge_sampling", out, 32'd14);

    apply(32'hFFFF_FFFF, 32'h0000_0001);
    check("wrap_all_ones_plus1", out, 32'h0000_0000);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("wrap_ones_plus_ones", out, 32'hFFFF_FFFE);
    apply(32'h7FFF_FFFF, 32'h0000_0001);
    check("max_pos_plus1", out, 32'h8000_0000);
    apply(32'h0000_000F, 32'h0000_0001);
    check("slice0_carry", out, 32'h0000_0010);
    apply(32'h0FFF_FFFF, 32'h0000_0001);
    check("all_slice_carry", out, 32'h1000_0000);
    apply(32'h00FF_00FF, 32'h0001_0001);
    check("split_carry", out, 32'h0100_0100);

    apply(32'd100, 32'd1);
    check("b2b_1", out, 32'd101);
    apply(32'd200, 32'd2);
    check("b2b_2", out, 32'd202);
    apply(32'd300, 32'd3);
    check("b2b_3", out, 32'd303);

    rst = 1'b1;
    apply(32'd400, 32'd4);
    check("mid_reset", out, 32'd0);
    rst = 1'b0;
    apply(32'd500, 32'd5);
    check("resume_1", out, 32'd505);
    apply(32'd600, 32'd6);
    check("resume_2", out, 32'd606);

    for (int unsigned n = 0; n < 10000; n++) begin
      ra   = $urandom;
      rb   = $urandom;
      rexp = ra + rb;
      apply(ra, rb);
      check("random", out, rexp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_adder32
